multilane_accumulator: RTL

Parametrised, multi-channel successor to the fixed 8-bit sum/overflow datapath. It holds LANES independent unsigned accumulators of WIDTH bits. It accepts (lane, value) operands over a valid/ready handshake and returns the updated sum and overflow one cycle later. Wrap or saturate mode is selectable at run time, and a sequenced clear sweep resets all lanes. It sits between the stimulus source and the top-level result outputs of the multilayer designs.

---
 rtl/multilane_acc_pkg.sv | 36 +++
 rtl/multilane_accumulator_acc_lane.sv | 39 +++
 rtl/multilane_accumulator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multilane_acc_pkg.sv
// Shared types and arithmetic helper for the multi-lane accumulator.
// The state enum covers the idle/clear-sweep controller, and sat_add performs
// the wrap-or-saturate addition for any operand width up to SAT_ADD_MAX_W.
package multilane_acc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Widest operand sat_add handles; callers zero-extend into this width.
  localparam int SAT_ADD_MAX_W = 64;
  localparam logic [SAT_ADD_MAX_W:0] SAT_ADD_ONE = 1;

  // Adds two zero-extended operands of 'width' significant bits.
  // Returns {carry, result}. The result sits in the low 'width' bits and is
  // all-ones on carry when sat is set, otherwise the wrapped sum.
  function automatic logic [SAT_ADD_MAX_W:0] sat_add(
    input logic [SAT_ADD_MAX_W-1:0] acc,
    input logic [SAT_ADD_MAX_W-1:0] value,
    input logic                     sat,
    input int                       width
  );
    logic [SAT_ADD_MAX_W:0] raw;
    logic [SAT_ADD_MAX_W:0] mask;
    logic [SAT_ADD_MAX_W:0] res;
    logic                   carry;
    raw   = {1'b0, acc} + {1'b0, value};
    mask  = (SAT_ADD_ONE << width) - SAT_ADD_ONE;
    // Both operands are below 2**width, so any bit above the mask is the carry.
    carry = |(raw & ~mask);
    res   = (carry && sat) ? mask : (raw & mask);
    return {carry, res[SAT_ADD_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/multilane_accumulator_acc_lane.sv
// One accumulator lane: a WIDTH-bit running sum plus its sticky overflow flag.
// Clear and write never coincide: the parent only writes while idle and only
// clears during the sweep. Clear is still given priority.
module acc_lane
  import multilane_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] next_value,
  input  logic             next_ovf,
  output logic [WIDTH-1:0] acc,
  output logic             sticky
);

  logic [WIDTH-1:0] acc_reg;
  logic             sticky_reg;

  // Hold, clear or load the lane value and fold new carries into the sticky flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
    end else if (clr) begin
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
    end else if (we) begin
      acc_reg    <= next_value;
      sticky_reg <= sticky_reg | next_ovf;
    end
  end

  assign acc    = acc_reg;
  assign sticky = sticky_reg;

endmodule

// File: rtl/multilane_accumulator.sv
// LANES independent WIDTH-bit accumulators behind a valid/ready operand port.
// Each accepted (lane, value) is added in one cycle (wrap or saturate) and the
// result is reported the following cycle. clear_req starts a one-lane-per-cycle
// sweep that zeroes every accumulator and sticky flag.
// Optional build macro: MULTILANE_ACC_TOTAL_EN adds a registered 'total' port
// carrying the sum of all lanes.
module multilane_accumulator
  import multilane_acc_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int LANES  = 4,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_lane,
  input  logic [WIDTH-1:0]  in_value,
  input  logic              sat_mode,
  input  logic              clear_req,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_lane,
  output logic [WIDTH-1:0]  sum,
  output logic              overflow,
  output logic [LANES-1:0]  ovf_sticky
`ifdef MULTILANE_ACC_TOTAL_EN
  ,
  output logic [WIDTH+LANE_W-1:0] total
`endif
);

  state_t            state_reg, state_next;
  logic [LANE_W-1:0] sweep_idx_reg, sweep_idx_next;

  logic              accept;
  logic              lane_hit;
  logic [LANES-1:0]  lane_sel;
  logic [WIDTH-1:0]  acc_q [LANES];
  logic [WIDTH-1:0]  acc_sel;
  logic [SAT_ADD_MAX_W:0] add_res;
  logic              add_carry;
  logic [WIDTH-1:0]  add_sum;

  logic              out_valid_reg;
  logic [LANE_W-1:0] out_lane_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              overflow_reg;

  // Ready depends only on the registered state, never on in_valid.
  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;

  // Decode the target lane and pick its current value; out-of-range indices
  // select nothing, so such operands are consumed without effect.
  always_comb begin
    lane_sel = '0;
    acc_sel  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane == LANE_W'(i)) begin
        lane_sel[i] = 1'b1;
        acc_sel     = acc_q[i];
      end
    end
  end

  assign lane_hit  = accept && (|lane_sel);
  assign add_res   = sat_add(SAT_ADD_MAX_W'(acc_sel), SAT_ADD_MAX_W'(in_value), sat_mode, WIDTH);
  assign add_carry = add_res[SAT_ADD_MAX_W];
  assign add_sum   = add_res[WIDTH-1:0];

  // Bits of the helper's wide result above WIDTH are always zero.
  if (WIDTH < SAT_ADD_MAX_W) begin : g_add_res_hi
    logic add_res_hi_unused;
    assign add_res_hi_unused = |add_res[SAT_ADD_MAX_W-1:WIDTH];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    acc_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .we        (accept && lane_sel[gi]),
      .clr       ((state_reg == CLEAR) && (sweep_idx_reg == LANE_W'(gi))),
      .next_value(add_sum),
      .next_ovf  (add_carry),
      .acc       (acc_q[gi]),
      .sticky    (ovf_sticky[gi])
    );
  end

  // Controller state and sweep index registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  // Enter the sweep on clear_req while idle; walk one lane per cycle and
  // return to idle after the last lane. Requests during the sweep are ignored.
  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next     = CLEAR;
          sweep_idx_next = '0;
        end
      end
      CLEAR: begin
        if (sweep_idx_reg == LANE_W'(LANES - 1)) begin
          state_next     = IDLE;
          sweep_idx_next = '0;
        end else begin
          sweep_idx_next = sweep_idx_reg + 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        sweep_idx_next = '0;
      end
    endcase
  end

  // Result registers: pulse out_valid for an in-range accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_lane_reg  <= '0;
      sum_reg       <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      out_valid_reg <= lane_hit;
      if (lane_hit) begin
        out_lane_reg <= in_lane;
        sum_reg      <= add_sum;
        overflow_reg <= add_carry;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_lane  = out_lane_reg;
  assign sum       = sum_reg;
  assign overflow  = overflow_reg;

`ifdef MULTILANE_ACC_TOTAL_EN
  localparam int TOT_W = WIDTH + LANE_W;

  logic [TOT_W-1:0] total_next, total_reg;

  // Sum every lane; TOT_W bits cover LANES * (2**WIDTH - 1) without wrapping.
  always_comb begin
    total_next = '0;
    for (int i = 0; i < LANES; i++) begin
      total_next = total_next + TOT_W'(acc_q[i]);
    end
  end

  // Register the total so it trails any accumulator change by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      total_reg <= '0;
    end else begin
      total_reg <= total_next;
    end
  end

  assign total = total_reg;
`endif

endmodule
